// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, ALU select codes
// and the captured-operation record.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_INC = 4'b1000;
  localparam logic [3:0] OP_DEC = 4'b1001;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        sel;
    logic              id;
  } arb_op_t;

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU. Results are truncated to 8 bits; unused select
// codes produce zero.
module alu_8bit
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [3:0]        sel_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (sel_i)
      OP_ADD: result_o = a_i + b_i;
      OP_SUB: result_o = a_i - b_i;
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_NOT: result_o = ~a_i;
      OP_SHL: result_o = {a_i[DATA_W-2:0], 1'b0};
      OP_SHR: result_o = {1'b0, a_i[DATA_W-1:1]};
      OP_INC: result_o = a_i + 1'b1;
      OP_DEC: result_o = a_i - 1'b1;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one alu_8bit: IDLE grants, EXEC computes,
// RESP holds the result. ALU_ARB_FIXED_PRIO_EN makes requester 0 win every tie.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 8  // must stay 8 to match alu_8bit
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_id,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  arb_op_t           op_q, op_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] alu_res;
  logic              gnt0, gnt1, take;

`ifndef ALU_ARB_FIXED_PRIO_EN
  // 1 means requester 1 was granted last, so requester 0 wins the next tie.
  logic last_q, last_d;
`endif

  alu_8bit u_alu (
    .a_i      (op_q.a),
    .b_i      (op_q.b),
    .sel_i    (op_q.sel),
    .result_o (alu_res)
  );

  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    gnt0 = req0_valid;
`else
    gnt0 = req0_valid && (!req1_valid || last_q);
`endif
    gnt1 = req1_valid && !gnt0;
    take = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
  end

  assign req0_ready = take && gnt0;
  assign req1_ready = take && gnt1;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    id_d    = id_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: if (take) begin
        state_d = EXEC;
        if (gnt0) op_d = '{a: req0_a, b: req0_b, sel: req0_sel, id: 1'b0};
        else      op_d = '{a: req1_a, b: req1_b, sel: req1_sel, id: 1'b1};
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_d = gnt1;
`endif
      end
      EXEC: begin
        state_d = RESP;
        res_d   = alu_res;
        id_d    = op_q.id;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      res_q   <= '0;
      id_q    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      id_q    <= id_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = res_q;
  assign rsp_id     = id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural model predicts grants and
// results; a negedge monitor checks readies, response timing and data.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       rv [2];
  logic [7:0] ra [2];
  logic [7:0] rb [2];
  logic [3:0] rs [2];
  logic       req0_ready, req1_ready, rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0] rsp_result;
  logic [1:0] acc;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_a(ra[0]), .req0_b(rb[0]), .req0_sel(rs[0]),
    .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_a(ra[1]), .req1_b(rb[1]), .req1_sel(rs[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_id(rsp_id),
    .busy(busy)
  );

  typedef struct { int res; int id; int cyc; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0, cyc = 0, last_gnt = 1;
  bit rst_prev = 0;

  function automatic int model(int a, int b, int sel);
    case (sel)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return 255 - a;
      6: return (a * 2) % 256;
      7: return a / 2;
      8: return (a + 1) % 256;
      9: return (a + 255) % 256;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: model idle means no outstanding op; responses due 2 cycles after accept.
  always @(negedge clk) begin
    bit idle, exp_v;
    int g;
    cyc++;
    if (rst) begin
      chk("ready_in_reset", {req1_ready, req0_ready}, 0);
      sb.delete();
      last_gnt = 1;
      acc      = 2'b00;
      rst_prev = 1;
    end else begin
      if (rst_prev) begin
        chk("reset_result", rsp_result, 0);
        chk("reset_id", rsp_id, 0);
      end
      rst_prev = 0;
      idle  = (sb.size() == 0);
      exp_v = !idle && (cyc >= sb[0].cyc + 2);
      chk("rsp_valid", rsp_valid, exp_v);
      chk("busy", busy, !idle);
      if (rsp_valid && exp_v) begin
        chk("rsp_result", rsp_result, sb[0].res);
        chk("rsp_id", rsp_id, sb[0].id);
        if (rsp_ready) void'(sb.pop_front());
      end
      g = -1;
      if (idle) begin
        if (rv[0] && rv[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          g = 0;
`else
          g = (last_gnt == 0) ? 1 : 0;
`endif
        end else if (rv[0]) g = 0;
        else if (rv[1]) g = 1;
      end
      chk("req0_ready", req0_ready, g == 0);
      chk("req1_ready", req1_ready, g == 1);
      if (g >= 0) begin
        sb.push_back('{res: model(ra[g], rb[g], rs[g]), id: g, cyc: cyc});
        last_gnt = g;
      end
      acc = {rv[1] && req1_ready, rv[0] && req0_ready};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input int id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    bit got = 0;
    ra[id] = a; rb[id] = b; rs[id] = s; rv[id] = 1'b1;
    for (int k = 0; k < 12 && !got; k++) begin
      step();
      if (acc[id]) begin
        rv[id] = 1'b0;
        got = 1;
      end
    end
    chk("accept_in_time", got, 1);
    rv[id] = 1'b0;
  endtask

  task automatic run(input int n, input int pv, input int pr, input bit cancel);
    for (int k = 0; k < n; k++) begin
      step();
      rsp_ready = ($urandom % 100) < pr;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) rv[i] = 1'b0;
        else if (rv[i] && cancel && ($urandom % 16 == 0)) rv[i] = 1'b0;
        if (!rv[i] && ($urandom % 100) < pv) begin
          rv[i] = 1'b1;
          ra[i] = 8'($urandom);
          rb[i] = 8'($urandom);
          rs[i] = 4'($urandom % 12);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; rs[i] = '0;
    end
    rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    single(0, 8'hD5, 8'h4E, OP_ADD);
    run(5, 0, 100, 0);
    single(1, 8'h00, 8'h01, OP_SUB);
    run(5, 0, 100, 0);
    // Both requesters continuously valid: alternation (or req0 starvation-free wins).
    run(20, 100, 100, 0);
    run(6, 0, 100, 0);
    // Backpressure with both requesters waiting.
    run(9, 100, 0, 0);
    run(8, 100, 100, 0);
    run(6, 0, 100, 0);
    // Reset pulsed while the operation is in EXEC.
    single(0, 8'h12, 8'h34, OP_XOR);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(5, 0, 100, 0);
    run(3000, 40, 70, 1);
    run(10, 0, 100, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, default 8, operand/result width; SHALL equal 8 (alu_8bit width).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req0_a, req0_b  input  8 each  requester 0 operands.
REQ-008 req0_sel  input  4  requester 0 ALU select code.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as REQ-005..008, for requester 1.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_result  output  8  ALU result.
REQ-013 rsp_id  output  1  index of requester that issued the result.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-016 IDLE: if any reqN_valid, grant one requester; assert its reqN_ready combinationally in that cycle; capture a, b, sel, id into operand registers; go to EXEC.
REQ-017 reqN_ready SHALL be high only in IDLE, only for the granted requester, and never for both requesters in the same cycle.
REQ-018 Arbitration: round-robin. If both valid, grant the requester not granted last; if only one is valid, grant it. The last-grant pointer updates only on a grant.
REQ-019 EXEC: alu_8bit is driven from the operand registers. Its result is registered into rsp_result and the captured id into rsp_id. Next state: RESP.
REQ-020 RESP: rsp_valid=1. rsp_result and rsp_id are held stable until rsp_valid&&rsp_ready, then the FSM goes to IDLE.
REQ-021 Latency: accept at cycle N, rsp_valid high at N+2; minimum issue interval is 3 cycles.
REQ-022 Results are 8-bit; carry/overflow beyond bit 7 is discarded (no wrap handling beyond truncation).
REQ-023 Requesters SHALL hold valid and operands stable until ready. Dropping valid before ready cancels the request with no side effects.
REQ-024 Backpressure: while rsp_ready=0 in RESP, no new grant occurs and both reqN_ready stay 0.
REQ-025 A request arriving in EXEC or RESP waits; it is arbitrated in the next IDLE cycle.

Reset
REQ-026 When rst=1 at a clock edge: state=IDLE, rsp_valid=0, rsp_result=0, rsp_id=0, busy=0, operand registers=0, last-grant pointer=1 (requester 0 wins the first tie).
REQ-027 Reset in EXEC or RESP aborts the operation; no rsp_valid is produced for it.
REQ-028 reqN_ready SHALL be 0 in any cycle where rst=1.

Configuration
REQ-029 Macro ALU_ARB_FIXED_PRIO_EN:
- defined: requester 0 always wins ties, and the pointer is unused/removed;
- undefined: round-robin per REQ-018.

Structure
REQ-030 Shared package alu_pkg: FSM state typedef (IDLE/EXEC/RESP), ALU select encodings (OP_ADD=4'b0000, OP_SUB=4'b0001, ...), DATA_W constant.
REQ-031 One sub-module: existing alu_8bit, instantiated once, combinational, fed only from the operand registers.

Verification
REQ-032 Single op: rst released, req0 A=8'hD5 B=8'h4E sel=OP_ADD -> req0_ready in the same cycle; 2 cycles later rsp_valid=1, rsp_result=8'h23, rsp_id=0.
REQ-033 Tie after reset: both valid in the same cycle -> req0 granted first, then req1; rsp_id sequence 0,1; for the next tie, req0 wins again (alternation).
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_result/rsp_id stable, reqN_ready=0 throughout; on rsp_ready=1, IDLE next cycle.
REQ-035 Reset mid-op: rst pulsed during EXEC -> next cycle rsp_valid=0, busy=0, and no response for the aborted op.
REQ-036 Subtract wrap: A=8'h00 B=8'h01 sel=OP_SUB -> rsp_result=8'hFF.
REQ-037 With ALU_ARB_FIXED_PRIO_EN: both requesters continuously valid -> every rsp_id=0 until req0 drops valid.
